slice_sub_sequencer: RTL and testbench
======================================

Name: slice_sub_sequencer

Overview:
Multi-cycle wide subtractor controller. It computes a WIDTH-bit unsigned subtraction by time-multiplexing one 4-bit ripple_carry_subtractor slice, least-significant slice first, and chains the borrow between cycles in a register. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake. The block sits between an operand producer and a result consumer wherever a wide difference is needed but only one narrow subtractor is available.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NS, WIDTH/4, number of slices; derived, not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  operand handshake valid
in_ready  output  1  operand handshake ready
a  input  WIDTH  minuend, sampled on accept
b  input  WIDTH  subtrahend, sampled on accept
bin  input  1  borrow-in applied to slice 0 only, sampled on accept
out_valid  output  1  result handshake valid
out_ready  input  1  result handshake ready
diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (async assert, released synchronously by the environment): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, busy=0, slice index=0, borrow reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE. Registered state; outputs decoded from registered state and registers only, with no combinational input-to-output paths.
- IDLE: in_ready=1. When in_valid=1 at an edge (accept): capture a, b, bin into a_r, b_r, brw; set idx=0; go to RUN. Without in_valid, remain in IDLE.
- RUN: in_ready=0. Each cycle the slice is driven with A=a_r[4*idx+:4], B=b_r[4*idx+:4], bin=brw. At the edge: diff_r[4*idx+:4]<=Diff, brw<=Bout, idx<=idx+1. If idx==NS-1, go to DONE, set out_valid=1, and set bout=final Bout.
- DONE: out_valid=1; diff and bout are held stable. When out_ready=1 at an edge, go to IDLE and clear out_valid. in_ready=0 in DONE, so no accept occurs in the same cycle as the output handshake.
- Latency: out_valid rises exactly NS cycles after the accept edge (4 for WIDTH=16). Minimum accept-to-accept spacing is NS+2 cycles with out_ready held high.
- WIDTH=4 (NS=1): RUN lasts one cycle.
- idx is a counter of width clog2(NS) (minimum 1 bit). It never wraps past NS-1 and resets to 0 on accept.
- Changes on a, b, bin outside the accept edge are ignored. in_valid is ignored unless the state is IDLE.
- diff reads the partially written diff_r during RUN. It is only meaningful when out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is aborted with no result emitted, and all outputs return to reset values immediately.
- The slice borrow chain exists only through brw. There is no combinational path between slices.

Decomposition:
- Shared package slice_sub_pkg: SLICE_W=4 constant, state enum type {IDLE, RUN, DONE}, and a function computing NS and the idx width.
- One sub-module: the existing ripple_carry_subtractor, instantiated once (ports A, B, bin, Diff, Bout). The FSM, counter, and operand/result registers live in the top module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1 (borrow propagates through all 4 slices).
- a=0xFFFF, b=0x0000, bin=1 -> diff=0xFFFE, bout=0; then a=0x8000, b=0x8000, bin=1 -> diff=0xFFFF, bout=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE with in_valid=1 and new operands applied -> diff/bout stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE next cycle, and the pending operands are accepted on the following edge.
- Assert rst during the 2nd RUN cycle -> state IDLE, out_valid=0, diff=0, bout=0 immediately. The next operation a=0x0005, b=0x0003 -> diff=0x0002, bout=0.
- WIDTH=4 build: a=0xD, b=0xA, bin=0 -> diff=0x3, bout=0, out_valid 1 cycle after accept. Random 200-op regression against a reference model with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/slice_sub_pkg.sv
// Shared constants, FSM state type and sizing helpers for the slice-serial subtractor.
package slice_sub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_ns(input int unsigned width);
    return width / SLICE_W;
  endfunction

  // Slice index width; a single-slice build still keeps a 1-bit counter.
  function automatic int unsigned calc_idx_w(input int unsigned ns);
    if (ns > 1) return $clog2(ns);
    return 1;
  endfunction

endpackage

// File: rtl/ripple_carry_subtractor.sv
// 4-bit ripple-borrow subtractor slice: Diff = A - B - bin, Bout is the borrow out.
module ripple_carry_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       bin,
  output logic [3:0] Diff,
  output logic       Bout
);

  logic [4:0] br;

  always_comb begin
    br    = '0;
    Diff  = '0;
    br[0] = bin;
    for (int i = 0; i < 4; i++) begin
      Diff[i]  = A[i] ^ B[i] ^ br[i];
      br[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & br[i]);
    end
    Bout = br[4];
  end

endmodule

// File: rtl/slice_sub_sequencer.sv
// Wide unsigned subtractor that reuses one 4-bit slice over NS cycles, LSB slice first,
// carrying the borrow between cycles in a register; valid/ready on both sides.
module slice_sub_sequencer
  import slice_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int unsigned NS    = calc_ns(WIDTH);
  localparam int unsigned IDX_W = calc_idx_w(NS);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("slice_sub_sequencer: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               brw_q, brw_d;
  logic               bout_q, bout_d;
  logic               in_ready_q, out_valid_q, busy_q;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_diff;
  logic               slice_bout;
  logic               last_slice;

  assign slice_a    = a_q[SLICE_W*int'(idx_q) +: SLICE_W];
  assign slice_b    = b_q[SLICE_W*int'(idx_q) +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(NS - 1));

  ripple_carry_subtractor u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .bin  (brw_q),
    .Diff (slice_diff),
    .Bout (slice_bout)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[SLICE_W*int'(idx_q) +: SLICE_W] = slice_diff;
        brw_d = slice_bout;
        if (last_slice) begin
          bout_d  = slice_bout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so outputs never see inputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      brw_q       <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      brw_q       <= brw_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_slice_sub_sequencer.sv
// Self-checking bench: 16-bit and 4-bit builds against an arithmetic reference model.
module tb_slice_sub_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv16, ir16, bin16, ov16, or16, bo16, busy16;
  logic [15:0] a16, b16, d16;
  logic        iv4, ir4, bin4, ov4, or4, bo4, busy4;
  logic [3:0]  a4, b4, d4;

  slice_sub_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .busy(busy16)
  );

  slice_sub_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .bin(bin4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .bout(bo4), .busy(busy4)
  );

  // Reference: plain integer subtraction reduced modulo 2^w, borrow from the sign.
  function automatic void ref_sub(input int w, input longint av, input longint bv, input bit bi,
                                  output longint dv, output bit bo);
    longint r;
    r  = av - bv - longint'(bi);
    bo = (r < 0);
    dv = r & ((longint'(1) << w) - 1);
  endfunction

  // Runs one 16-bit operation from IDLE; returns result, latency and accept cycle.
  task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic bi, input int hold,
                      output logic [15:0] dv, output logic bo, output int lat, output int acc);
    a16 = av; b16 = bv; bin16 = bi; iv16 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    dv = d16; bo = bo16;
    repeat (hold) begin @(posedge clk); #1; end
    or16 = 1'b1; @(posedge clk); #1; or16 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi, input int hold,
                     output logic [3:0] dv, output logic bo, output int lat);
    a4 = av; b4 = bv; bin4 = bi; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0;
    while (!ov4 && lat < 40) begin @(posedge clk); #1; lat++; end
    dv = d4; bo = bo4;
    repeat (hold) begin @(posedge clk); #1; end
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv16 = 0; or16 = 0; a16 = '0; b16 = '0; bin16 = 0;
    iv4 = 0; or4 = 0; a4 = '0; b4 = '0; bin4 = 0;
    #1;
    n_checks++;
    if ({ir16, ov16, d16, bo16, busy16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset16: ir=%b ov=%b diff=%h bout=%b busy=%b, need 1 0 0000 0 0", ir16, ov16, d16, bo16, busy16);
    end
    n_checks++;
    if ({ir4, ov4, d4, bo4, busy4} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset4: ir=%b ov=%b diff=%h bout=%b busy=%b, need 1 0 0 0 0", ir4, ov4, d4, bo4, busy4);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] av [4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h8000};
    logic [15:0] bv [4] = '{16'h0234, 16'h0001, 16'h0000, 16'h8000};
    logic        bi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] ed [4] = '{16'h1000, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dv;
    logic        bo;
    int          lat, acc, prev_acc;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      op16(av[i], bv[i], bi[i], 0, dv, bo, lat, acc);
      n_checks++;
      if (dv !== ed[i] || bo !== eb[i]) begin
        n_fail++;
        $display("FAIL directed%0d: diff=%h bout=%b, need diff=%h bout=%b", i, dv, bo, ed[i], eb[i]);
      end
      n_checks++;
      if (lat != 4) begin
        n_fail++;
        $display("FAIL latency%0d: got %0d cycles, need 4", i, lat);
      end
      if (i > 0) begin
        n_checks++;
        if (acc - prev_acc != 6) begin
          n_fail++;
          $display("FAIL back_to_back%0d: spacing %0d cycles, need 6", i, acc - prev_acc);
        end
      end
      prev_acc = acc;
    end
  endtask

  task automatic test_backpressure();
    longint ed, ed2;
    bit     eb, eb2;
    int     lat;
    ref_sub(16, 64'h0000_C3A1, 64'h0000_D00F, 1'b0, ed, eb);
    ref_sub(16, 64'h0000_5A5A, 64'h0000_1234, 1'b1, ed2, eb2);
    a16 = 16'hC3A1; b16 = 16'hD00F; bin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    a16 = 16'h5A5A; b16 = 16'h1234; bin16 = 1'b1; iv16 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (d16 !== 16'(ed) || bo16 !== eb || ir16 !== 1'b0 || ov16 !== 1'b1) begin
        n_fail++;
        $display("FAIL hold%0d: diff=%h bout=%b ir=%b ov=%b, need diff=%h bout=%b ir=0 ov=1",
                 k, d16, bo16, ir16, ov16, 16'(ed), eb);
      end
      @(posedge clk); #1;
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    n_checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0) begin
      n_fail++;
      $display("FAIL release: ir=%b ov=%b busy=%b, need 1 0 0", ir16, ov16, busy16);
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
    n_checks++;
    if (ir16 !== 1'b0 || busy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_accept: ir=%b busy=%b, need 0 1", ir16, busy16);
    end
    lat = 0;
    while (!ov16 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (d16 !== 16'(ed2) || bo16 !== eb2 || lat != 4) begin
      n_fail++;
      $display("FAIL pending_result: diff=%h bout=%b lat=%0d, need diff=%h bout=%b lat=4",
               d16, bo16, lat, 16'(ed2), eb2);
    end
    or16 = 1'b1; @(posedge clk); #1; or16 = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] dv;
    logic        bo;
    int          lat, acc;
    a16 = 16'hFFFF; b16 = 16'h0001; bin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ir16, ov16, d16, bo16, busy16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort: ir=%b ov=%b diff=%h bout=%b busy=%b, need 1 0 0000 0 0", ir16, ov16, d16, bo16, busy16);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (ov16 !== 1'b0 || busy16 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: ov=%b busy=%b, need 0 0", ov16, busy16);
    end
    op16(16'h0005, 16'h0003, 1'b0, 0, dv, bo, lat, acc);
    n_checks++;
    if (dv !== 16'h0002 || bo !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL after_abort: diff=%h bout=%b lat=%0d, need diff=0002 bout=0 lat=4", dv, bo, lat);
    end
  endtask

  task automatic test_width4();
    logic [3:0] dv;
    logic       bo;
    int         lat;
    longint     ed;
    bit         eb;
    logic [3:0] av, bv;
    logic       bi;
    op4(4'hD, 4'hA, 1'b0, 0, dv, bo, lat);
    n_checks++;
    if (dv !== 4'h3 || bo !== 1'b0 || lat != 1) begin
      n_fail++;
      $display("FAIL w4_directed: diff=%h bout=%b lat=%0d, need diff=3 bout=0 lat=1", dv, bo, lat);
    end
    for (int i = 0; i < 50; i++) begin
      av = 4'($urandom); bv = 4'($urandom); bi = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op4(av, bv, bi, int'($urandom_range(0, 3)), dv, bo, lat);
      ref_sub(4, longint'(av), longint'(bv), bi, ed, eb);
      n_checks++;
      if (dv !== 4'(ed) || bo !== eb || lat != 1) begin
        n_fail++;
        $display("FAIL w4_random%0d: %h-%h-%b diff=%h bout=%b lat=%0d, need diff=%h bout=%b lat=1",
                 i, av, bv, bi, dv, bo, lat, 4'(ed), eb);
      end
    end
  endtask

  task automatic test_random16();
    logic [15:0] dv, av, bv;
    logic        bo, bi;
    int          lat, acc;
    longint      ed;
    bit          eb;
    for (int i = 0; i < 200; i++) begin
      av = 16'($urandom); bv = 16'($urandom); bi = 1'($urandom);
      if (i % 10 == 0) av = bv;
      repeat ($urandom_range(0, 3)) begin
        iv16 = 1'b0; @(posedge clk); #1;
      end
      op16(av, bv, bi, int'($urandom_range(0, 3)), dv, bo, lat, acc);
      ref_sub(16, longint'(av), longint'(bv), bi, ed, eb);
      n_checks++;
      if (dv !== 16'(ed) || bo !== eb || lat != 4) begin
        n_fail++;
        $display("FAIL random%0d: %h-%h-%b diff=%h bout=%b lat=%0d, need diff=%h bout=%b lat=4",
                 i, av, bv, bi, dv, bo, lat, 16'(ed), eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
